// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and a two-entry skid buffer.
// in_ready depends only on registered state (and reset), so out_ready never reaches it.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // state encoding doubles as the occupancy count
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] m_ctrl;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] s_data;
  logic              do_accept;
  logic              do_release;

  assign out_valid  = (state != EMPTY);
  assign in_ready   = (state != TWO) & ~reset;
  assign do_accept  = in_valid & in_ready;
  assign do_release = out_valid & out_ready;
  assign out_ctrl   = m_ctrl & {CTRL_W{out_valid}};
  assign out_data   = m_data;
  assign occupancy  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      m_ctrl <= '0;
      s_ctrl <= '0;
      m_data <= '0;
      s_data <= '0;
    end else if (flush) begin
      // data registers keep their value so out_data holds across the kill
      state  <= EMPTY;
      m_ctrl <= '0;
      s_ctrl <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (do_accept) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (do_accept && do_release) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
          end else if (do_accept) begin
            s_ctrl <= in_ctrl;
            s_data <= in_data;
            state  <= TWO;
          end else if (do_release) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (do_release) begin
            m_ctrl <= s_ctrl;
            m_data <= s_data;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios followed by random
// stall traffic, all compared against a queue-based reference model.
module tb_pipe_stage_skid;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  int checks = 0;
  int errors = 0;

  entry_t            q[$];
  logic [DATA_W-1:0] last_data = '0;
  int                max_occ = 0;
  logic [DATA_W-1:0] seen[$];

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from the falling edge, check outputs, then advance the model at the rising edge.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                       input logic ordy);
    logic   exp_ready, exp_valid, acc, rel, ir_before;
    entry_t head;
    reset = rst; flush = fl; in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy;
    #1;
    exp_ready = (q.size() < 2) && !rst;
    exp_valid = (q.size() > 0);
    head      = exp_valid ? q[0] : '{ctrl: '0, data: last_data};
    chk("in_ready",  64'(in_ready),  64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("out_data",  64'(out_data),  64'(head.data));
    chk("out_ctrl",  64'(out_ctrl),  exp_valid ? 64'(head.ctrl) : 64'd0);
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    // in_ready must not react combinationally to out_ready, in_valid or flush
    ir_before = in_ready;
    out_ready = ~ordy; in_valid = ~iv; flush = ~fl;
    #1;
    chk("in_ready_comb", 64'(in_ready), 64'(ir_before));
    out_ready = ordy; in_valid = iv; flush = fl;
    #1;
    acc = iv && exp_ready;
    rel = exp_valid && ordy;
    @(posedge clk);
    if (exp_valid) last_data = q[0].data;
    if (rst) begin
      q.delete();
      last_data = '0;
    end else if (fl) begin
      if (rel) seen.push_back(q[0].data);
      q.delete();
    end else begin
      if (rel) seen.push_back(q.pop_front().data);
      if (acc) q.push_back('{ctrl: ic, data: id});
    end
    if (q.size() > max_occ) max_occ = q.size();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_ctrl = 8'hFF; in_data = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    q.delete(); last_data = '0;

    // Reset held with in_valid high
    cycle(1, 0, 1, 8'hFF, 32'h1234_5678, 0);
    cycle(1, 0, 1, 8'hFF, 32'h1234_5678, 0);
    cycle(0, 0, 0, 8'h00, 32'h0, 0);

    // Streaming: 0x100..0x10F with out_ready high, then drain one cycle
    seen.delete(); max_occ = 0;
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 8'(i), 32'h100 + 32'(i), 1);
    cycle(0, 0, 0, 8'h00, 32'h0, 1);
    chk("stream_count", 64'(seen.size()), 64'd16);
    for (int i = 0; i < 16 && i < seen.size(); i++)
      chk("stream_data", 64'(seen[i]), 64'h100 + 64'(i));
    chk("stream_maxocc", 64'(max_occ), 64'd1);

    // Backpressure: offer A, B, C with out_ready low; C stays pending
    seen.delete();
    cycle(0, 0, 1, 8'h0A, 32'hA, 0);
    cycle(0, 0, 1, 8'h0B, 32'hB, 0);
    cycle(0, 0, 1, 8'h0C, 32'hC, 0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_occ", 64'(occupancy), 64'd2);
    cycle(0, 0, 1, 8'h0C, 32'hC, 1);
    cycle(0, 0, 1, 8'h0C, 32'hC, 1);
    cycle(0, 0, 0, 8'h00, 32'h0, 1);
    cycle(0, 0, 0, 8'h00, 32'h0, 1);
    chk("bp_count", 64'(seen.size()), 64'd3);
    if (seen.size() == 3) begin
      chk("bp_order0", 64'(seen[0]), 64'hA);
      chk("bp_order1", 64'(seen[1]), 64'hB);
      chk("bp_order2", 64'(seen[2]), 64'hC);
    end

    // Flush in TWO with a simultaneous 0xD offer
    seen.delete();
    cycle(0, 0, 1, 8'h11, 32'h11, 0);
    cycle(0, 0, 1, 8'h22, 32'h22, 0);
    cycle(0, 1, 1, 8'h0D, 32'hD, 0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 32'h0, 1);
    chk("flush_no_d", 64'(seen.size()), 64'd0);

    // Bubble control: ctrl 0xFF accepted, released, then nothing new
    cycle(0, 0, 1, 8'hFF, 32'h5A5A_0001, 0);
    chk("bubble_ctrl_live", 64'(out_ctrl), 64'hFF);
    cycle(0, 0, 0, 8'h00, 32'h0, 1);
    chk("bubble_ctrl_zero", 64'(out_ctrl), 64'h00);
    chk("bubble_data_hold", 64'(out_data), 64'h5A5A_0001);
    cycle(0, 0, 0, 8'h00, 32'h0, 1);

    // Random stall traffic
    for (int i = 0; i < 10000; i++) begin
      logic rst_r, fl_r;
      rst_r = ($urandom_range(0, 999) == 0);
      fl_r  = ($urandom_range(0, 63) == 0);
      cycle(rst_r, fl_r, 1'($urandom), 8'($urandom), 32'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer, flush, and bubble-safe control outputs. It is the common building block for every inter-stage boundary of the RISC-V core (IF/ID, ID/EX, EX/MEM, MEM/WB). It sustains one transfer per cycle with no combinational path from `out_ready` to `in_ready`. While the stage holds no valid entry, its control bits are forced to zero so that a bubble cannot cause side effects downstream.

## Interface
Parameters:
- `DATA_W`, default 32: width of the datapath payload (ALU result, PC, store data, rd, ...).
- `CTRL_W`, default 8: width of the control payload (MemRead, MemWrite, RegWrite, Branch, ...). These bits are zeroed on bubbles and flush.

Ports:
- `clk` (in, 1): clock; all state updates on the rising edge.
- `reset` (in, 1): synchronous, active-high.
- `flush` (in, 1): synchronous kill of all held entries (branch taken, exception).
- `in_valid` (in, 1): upstream has an entry.
- `in_ready` (out, 1): stage can accept an entry; driven from registered state only.
- `in_ctrl` (in, `CTRL_W`): upstream control payload.
- `in_data` (in, `DATA_W`): upstream data payload.
- `out_valid` (out, 1): stage presents a valid entry.
- `out_ready` (in, 1): downstream accepts the entry.
- `out_ctrl` (out, `CTRL_W`): control payload; all zero whenever `out_valid`=0.
- `out_data` (out, `DATA_W`): data payload; holds its last value when `out_valid`=0.
- `occupancy` (out, 2): number of held entries, 0..2.

## Operation
- Handshake events:
  - `accept` = `in_valid` & `in_ready`.
  - `release` = `out_valid` & `out_ready`.
- Storage:
  - Main register (`m_ctrl`, `m_data`) drives the outputs.
  - Skid register (`s_ctrl`, `s_data`) holds an overflow entry.
- States:
  - EMPTY (`occupancy`=0).
  - ONE (`occupancy`=1, main valid).
  - TWO (`occupancy`=2, main and skid valid).
- Output decode:
  - `out_valid` = (state != EMPTY).
  - `in_ready` = (state != TWO) & !`reset`.
- Transitions, evaluated in priority order:
  1. `reset`: go to EMPTY. Clear `m_ctrl`, `s_ctrl`, `m_data`, `s_data`.
  2. `flush`: go to EMPTY. Clear `m_ctrl` and `s_ctrl`; data registers hold. An `accept` in the same cycle is dropped. A `release` in the same cycle completes normally, since the consumer has taken the entry.
  3. EMPTY:
     - `accept`: main <= in, go to ONE.
     - otherwise stay in EMPTY.
  4. ONE:
     - `accept` & `release`: main <= in, stay in ONE.
     - `accept` & !`release`: skid <= in, go to TWO.
     - !`accept` & `release`: go to EMPTY.
     - neither: hold.
  5. TWO:
     - `release`: main <= skid, go to ONE.
     - otherwise hold. No `accept` is possible because `in_ready`=0.
- Ordering: entries leave in strict arrival order. The skid entry is never presented ahead of the main entry.
- `out_ctrl` = `m_ctrl` & {`CTRL_W`{`out_valid`}}. `out_data` = `m_data` unconditionally.
- Payload is never modified or combined; widths pass through bit-exact.

## Timing
- Reset values:
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0.
  - `in_ready`=0 while `reset`=1, and 1 from the first cycle after `reset` is deasserted.
- Latency: an entry accepted at edge N is visible on `out_*` after edge N (1 cycle) when the stage was EMPTY, or when it was ONE with a `release` in the same cycle.
- Throughput: 1 entry/cycle with `out_ready` held high. No bubbles are inserted.
- Backpressure: with `out_ready`=0 the stage absorbs 2 entries. `in_ready` falls in the cycle after the second `accept`.
- `in_ready` has zero combinational dependence on `out_ready`, `in_valid`, or `flush`.
- After a flush, `out_valid`=0 and `in_ready`=1 from the next cycle. The first new entry can be accepted in that cycle.
- A reset or flush asserted mid-backpressure (state TWO) discards both entries within one cycle.

## Test plan
- Reset: assert `reset` for 2 cycles with `in_valid`=1 → `out_valid`=0, `out_ctrl`=0, `out_data`=0, `in_ready`=0; after release, `in_ready`=1 and `occupancy`=0.
- Streaming: `out_ready`=1, present `in_data` = 0x100, 0x101, ... 0x10F on consecutive cycles → identical sequence on `out_data`, 1 cycle later, with no gaps; `occupancy` stays ≤1.
- Backpressure: `out_ready`=0, offer 0xA, 0xB, 0xC → 0xA and 0xB are accepted, `in_ready`=0 with 0xC pending, `occupancy`=2; raise `out_ready` → output order 0xA, 0xB, 0xC.
- Flush in TWO with a simultaneous `in_valid` of 0xD → next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0; 0xD never appears on the output.
- Bubble control: `in_ctrl`=0xFF accepted then released with no new input → `out_ctrl`=0x00 while `out_valid`=0, and `out_data` holds the last value.
- Random stall: random `in_valid` and `out_ready` over 10k cycles against a reference FIFO model → no loss, no duplication, order preserved, and `in_ready` never changes within a cycle in response to `out_ready`.
